divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, divisor/remainder width; dividend/quotient are 2*WIDTH.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  2*WIDTH  unsigned numerator.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator.
REQ-007 SHALL have port: quotient  output  2*WIDTH  registered result.
REQ-008 SHALL have port: remainder  output  WIDTH  registered result.
REQ-009 SHALL have port: div_by_zero  output  1  registered flag, valid with finish.
REQ-010 SHALL have port: finish  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, CALC.
REQ-012 SHALL, in IDLE with start=1 at an edge, latch dividend and divisor, clear quotient, remainder, div_by_zero and the (WIDTH+1)-bit partial remainder, and enter CALC.
REQ-013 SHALL perform restoring division MSB-first, one dividend bit per CALC cycle, 2*WIDTH iterations.
REQ-014 SHALL, per iteration: shift partial remainder left by 1, shift in next dividend bit, subtract divisor if the result >= divisor, and shift the resulting quotient bit (1 on subtract, else 0) into quotient LSB.
REQ-015 SHALL hold partial remainder in WIDTH+1 bits; no overflow is possible for any nonzero divisor.
REQ-016 SHALL, after the iteration at the 2*WIDTH-th edge following acceptance, return to IDLE, drive remainder = partial remainder[WIDTH-1:0] and pulse finish for exactly one cycle.
REQ-017 SHALL keep quotient, remainder and div_by_zero stable after finish until the next accepted start.
REQ-018 SHALL ignore start while in CALC; the in-flight operation is unaffected.
REQ-019 SHALL accept start in the cycle finish is high (back-to-back operation).
REQ-020 SHALL, for divisor = 0, set div_by_zero=1 and produce quotient = all ones and remainder = dividend[WIDTH-1:0].
REQ-021 SHALL use a counter that clears in IDLE and wraps to 0 on the final iteration.

Reset
REQ-022 SHALL, on rst=1 at an edge, set state IDLE, counter 0, quotient 0, remainder 0, div_by_zero 0, finish 0, latched operands 0.
REQ-023 SHALL, on reset during CALC, abandon the operation without asserting finish.
REQ-024 SHALL give rst priority over start in the same cycle.

Configuration
REQ-025 SHALL support macro DIVIDER_ZERO_FAST_EN.
REQ-026 SHALL, with DIVIDER_ZERO_FAST_EN defined, finish a divisor=0 request one edge after acceptance, with REQ-020 results.
REQ-027 SHALL, without DIVIDER_ZERO_FAST_EN, run the full 2*WIDTH iterations for divisor=0 (constant latency, no data-dependent timing), with REQ-020 results.

Structure
REQ-028 SHALL place the state encoding (IDLE, CALC) and the default WIDTH constant in shared package divider_pkg.
REQ-029 SHALL put one restoring step (shift, compare, conditional subtract, quotient bit) in combinational sub-module divider_step; the FSM, counter and registers stay in divider.

Verification (WIDTH=8)
REQ-030 SHALL cover: 1000 / 7 -> quotient 142, remainder 6, div_by_zero 0, finish exactly 16 edges after acceptance.
REQ-031 SHALL cover: 0xFFFF / 0xFF -> quotient 257, remainder 0; then 5 / 9 started in the finish cycle -> quotient 0, remainder 5.
REQ-032 SHALL cover: 0x1234 / 0 -> quotient 0xFFFF, remainder 0x34, div_by_zero 1; latency 1 edge with DIVIDER_ZERO_FAST_EN, 16 without.
REQ-033 SHALL cover: start 200/3 asserted again with different operands mid-CALC -> second start ignored, quotient 66, remainder 2.
REQ-034 SHALL cover: rst asserted at iteration 5 of 1000/7 -> all outputs 0, no finish; subsequent 1000/7 -> quotient 142, remainder 6.
REQ-035 SHALL cover: random nonzero-divisor sweep vs. reference model -> quotient*divisor+remainder == dividend and remainder < divisor for every case.

Source files
------------

// File: rtl/divider_pkg.sv
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared state encoding and default width for the divider.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package divider_pkg;

   localparam int c_default_width = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/divider_step.sv
// ============================================================================
//  Module      : divider_step
//  Description : One restoring-division step: shift, compare, subtract, q bit.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module divider_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] w_shifted;
   logic [WIDTH:0] w_divisor_ext;
   logic           w_unused_msb;

   // The incoming remainder is always below the divisor, so its MSB is
   // shifted out without loss (divide-by-zero only keeps the low bits).
   assign w_unused_msb  = rem_in[WIDTH];
   assign w_shifted     = {rem_in[WIDTH-1:0], bit_in};
   assign w_divisor_ext = {1'b0, divisor};

   always_comb begin
      q_bit   = 1'b0;
      rem_out = w_shifted;
      if (w_shifted >= w_divisor_ext) begin
         q_bit   = 1'b1;
         rem_out = w_shifted - w_divisor_ext;
      end
   end

endmodule

`default_nettype wire

// File: rtl/divider.sv
// ============================================================================
//  Module      : divider
//  Description : Iterative restoring divider, 2*WIDTH / WIDTH, one bit per
//                cycle. Optional macro DIVIDER_ZERO_FAST_EN shortcuts x/0.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic [2*WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero,
   output logic                 finish
);

   localparam int                 c_cnt_w     = $clog2(2*WIDTH);
   localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(2*WIDTH - 1);

   state_t               state_q, state_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   dividend_q, dividend_d;
   logic [WIDTH-1:0]     divisor_q, divisor_d;
   logic [WIDTH:0]       part_q, part_d;
   logic [2*WIDTH-1:0]   quotient_q, quotient_d;
   logic [WIDTH-1:0]     remainder_q, remainder_d;
   logic                 dbz_q, dbz_d;
   logic                 finish_q, finish_d;

   logic [WIDTH:0]       w_step_rem;
   logic                 w_step_qbit;

   // The latched dividend is shifted left each iteration; its MSB feeds the step.
   divider_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in  (part_q),
      .bit_in  (dividend_q[2*WIDTH-1]),
      .divisor (divisor_q),
      .rem_out (w_step_rem),
      .q_bit   (w_step_qbit)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      part_d      = part_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      finish_d    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               dividend_d  = dividend;
               divisor_d   = divisor;
               part_d      = '0;
               quotient_d  = '0;
               remainder_d = '0;
               dbz_d       = 1'b0;
               state_d     = CALC;
            end
         end
         CALC: begin
`ifdef DIVIDER_ZERO_FAST_EN
            if (divisor_q == '0) begin
               quotient_d  = '1;
               remainder_d = dividend_q[WIDTH-1:0];
               dbz_d       = 1'b1;
               finish_d    = 1'b1;
               cnt_d       = '0;
               state_d     = IDLE;
            end else
`endif
            begin
               part_d     = w_step_rem;
               quotient_d = {quotient_q[2*WIDTH-2:0], w_step_qbit};
               dividend_d = dividend_q << 1;
               cnt_d      = cnt_q + c_cnt_w'(1);
               if (cnt_q == c_last_iter) begin
                  // Zero divisor falls out of the plain algorithm: all-ones
                  // quotient and the low dividend bits as remainder.
                  cnt_d       = '0;
                  remainder_d = w_step_rem[WIDTH-1:0];
                  dbz_d       = (divisor_q == '0);
                  finish_d    = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         part_q      <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         finish_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         part_q      <= part_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         finish_q    <= finish_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;
   assign finish      = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
//  Module      : tb_divider
//  Description : Directed and random self-checking bench for divider (WIDTH=8).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_divider;

   localparam int W = 8;

   logic            clk;
   logic            rst;
   logic            start;
   logic [2*W-1:0]  dividend;
   logic [W-1:0]    divisor;
   logic [2*W-1:0]  quotient;
   logic [W-1:0]    remainder;
   logic            div_by_zero;
   logic            finish;

   int total = 0;
   int bad   = 0;

   divider #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .finish      (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_finish(output int lat);
      lat = 0;
      while (finish !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   int lat;
   int fin_cnt;
   int exp_zero_lat;
   logic [2*W-1:0] ra;
   logic [W-1:0]   rb;

   initial begin
`ifdef DIVIDER_ZERO_FAST_EN
      exp_zero_lat = 1;
`else
      exp_zero_lat = 16;
`endif
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) tick();
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      check("rst_finish", finish, 0);
      rst = 1'b0;
      tick();

      // 1000 / 7
      start_op(16'd1000, 8'd7);
      wait_finish(lat);
      check("div1000_7_latency", lat, 16);
      check("div1000_7_q", quotient, 142);
      check("div1000_7_r", remainder, 6);
      check("div1000_7_dbz", div_by_zero, 0);
      tick();
      check("finish_one_cycle", finish, 0);
      check("hold_q", quotient, 142);
      check("hold_r", remainder, 6);

      // 0xFFFF / 0xFF then back-to-back 5 / 9
      start_op(16'hFFFF, 8'hFF);
      wait_finish(lat);
      check("ffff_ff_latency", lat, 16);
      check("ffff_ff_q", quotient, 257);
      check("ffff_ff_r", remainder, 0);
      start_op(16'd5, 8'd9);
      wait_finish(lat);
      check("b2b_5_9_latency", lat, 16);
      check("b2b_5_9_q", quotient, 0);
      check("b2b_5_9_r", remainder, 5);

      // divide by zero
      start_op(16'h1234, 8'd0);
      wait_finish(lat);
      check("zero_latency", lat, exp_zero_lat);
      check("zero_q", quotient, 16'hFFFF);
      check("zero_r", remainder, 8'h34);
      check("zero_dbz", div_by_zero, 1);

      // start during CALC ignored
      start_op(16'd200, 8'd3);
      repeat (5) tick();
      start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
      tick();
      start = 1'b0;
      wait_finish(lat);
      check("midstart_latency", lat + 6, 16);
      check("midstart_q", quotient, 66);
      check("midstart_r", remainder, 2);
      check("midstart_dbz", div_by_zero, 0);

      // reset in the middle of an operation
      start_op(16'd1000, 8'd7);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_q", quotient, 0);
      check("midrst_r", remainder, 0);
      check("midrst_dbz", div_by_zero, 0);
      fin_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (finish === 1'b1) fin_cnt++;
         tick();
      end
      check("midrst_no_finish", fin_cnt, 0);
      start_op(16'd1000, 8'd7);
      wait_finish(lat);
      check("after_rst_latency", lat, 16);
      check("after_rst_q", quotient, 142);
      check("after_rst_r", remainder, 6);

      // random nonzero-divisor sweep
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 8'($urandom_range(1, 255));
         start_op(ra, rb);
         wait_finish(lat);
         check("rand_latency", lat, 16);
         check("rand_q", quotient, ra / rb);
         check("rand_r", remainder, ra % rb);
         check("rand_r_lt_d", (remainder < rb), 1);
         check("rand_dbz", div_by_zero, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
